ucaspian_wb_bridge: RTL and testbench

Second-generation Wishbone slave bridge between a bus host and the uCaspian core's byte-stream command/response ports. It owns the command FIFO (bus to core) and response FIFO (core to bus), and exposes a register map with status, FIFO levels, a programmable timeout, blocking/non-blocking access modes, FIFO flush and an interrupt. Unlike the first generation, the core is not instantiated inside; the block sits between the SoC interconnect and a separately instantiated core.

---
 rtl/ucaspian_wb_bridge.sv | 382 ++++++++++++++++++++++++++++++++++++++
 tb/tb_ucaspian_wb_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ucaspian_wb_bridge.sv
// ucaspian_wb_bridge
//
// This is a Wishbone classic slave that sits between the SoC bus and a separately
// instantiated uCaspian core. It has two byte FIFOs:
//   - a command FIFO carries bytes from the bus to the core;
//   - a response FIFO carries bytes from the core to the bus.
// The core-side ports of both FIFOs are valid/ready byte streams.
//
// Register map, decoded on wb_adr_i[2:0]:
//   0 STATUS (RO)
//       [0]     cmd full
//       [1]     rsp empty
//       [2]     timeout sticky
//       [3]     overflow sticky
//       [7:4]   Version
//       [15:8]  cmd level
//       [23:16] rsp level
//   1 RSP    (RO)  a read pops one byte; [8] valid, [7:0] data
//   2 CMD    (WO)  a write pushes wb_dat_i[7:0]
//   3 CTRL   (RW)
//       [0]     non-blocking
//       [1]     irq on rsp non-empty
//       [2]     irq on cmd empty
//       [3]     irq on timeout sticky
//       [4]     core soft reset
//       [8+:TW] timeout limit (0 = no timeout)
//   4 CLEAR  (WO)
//       [0] flush cmd
//       [1] flush rsp
//       [2] clear timeout sticky
//       [3] clear overflow sticky
//
// Ports:
//   wb_clk_i, wb_rst_ni            clock, async active-low reset
//   wb_adr_i/dat_i/sel_i/we_i/stb_i/cyc_i
//                                  Wishbone request (sel ignored)
//   wb_dat_o, wb_ack_o, wb_err_o   registered Wishbone response
//   irq_o                          registered level interrupt
//   m_data_o/m_valid_o/m_ready_i   command byte stream to the core
//   s_data_i/s_valid_i/s_ready_o   response byte stream from the core
//   core_reset_o                   active-high reset for the core
//
// Access FSM:
//   state | meaning
//   IDLE  | waiting for stb&cyc; completes the access at once if it can
//   WAIT  | access stalled on a FIFO; timer counts toward the limit
//   ACK   | one-cycle ack/err strobe with registered data; stb ignored

// First-word fall-through byte FIFO. The pointers carry an extra wrap bit,
// so both full and empty can be told apart without a separate counter.
module ucaspian_wb_fifo #(
  parameter int unsigned Depth    = 32,
  parameter int unsigned PtrWidth = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [7:0]        data_i,
  input  logic              pop_i,
  output logic [7:0]        data_o,
  output logic [PtrWidth:0] level_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              empty_next_o
);

  logic [7:0]        mem_q [Depth];
  logic [PtrWidth:0] wr_q, wr_d, rd_q, rd_d;
  logic              push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PtrWidth] != rd_q[PtrWidth]) &&
                   (wr_q[PtrWidth-1:0] == rd_q[PtrWidth-1:0]);
  assign level_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[PtrWidth-1:0]];

  // When the FIFO is full, a push is still taken if a pop happens in the same
  // cycle. The slot being read out this cycle is the one that gets refilled.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q + {{PtrWidth{1'b0}}, push_ok};
    rd_d = rd_q + {{PtrWidth{1'b0}}, pop_ok};
    // A flush wins over any push or pop in the same cycle.
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  assign empty_next_o = (wr_d == rd_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_q[PtrWidth-1:0]] <= data_i;
    end
  end

endmodule

module ucaspian_wb_bridge #(
  parameter int unsigned FifoDepth      = 32,
  parameter int unsigned AdrWidth       = 30,
  parameter int unsigned DatWidth       = 32,
  parameter int unsigned TimeoutWidth   = 8,
  parameter int unsigned DefaultTimeout = 127,
  parameter bit          ErrEnable      = 1'b1,
  parameter logic [3:0]  Version        = 4'h2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [AdrWidth-1:0] wb_adr_i,
  input  logic [DatWidth-1:0] wb_dat_i,
  output logic [DatWidth-1:0] wb_dat_o,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                irq_o,
  output logic [7:0]          m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  input  logic [7:0]          s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic                core_reset_o
);

  localparam int unsigned LvlWidth = $clog2(FifoDepth) + 1;

  localparam logic [2:0] AdrStatus = 3'd0;
  localparam logic [2:0] AdrRsp    = 3'd1;
  localparam logic [2:0] AdrCmd    = 3'd2;
  localparam logic [2:0] AdrCtrl   = 3'd3;
  localparam logic [2:0] AdrClear  = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } state_e;

  state_e                  state_q, state_d;
  logic [TimeoutWidth-1:0] timer_q, timer_d;
  logic [TimeoutWidth-1:0] limit_q, limit_d;
  logic [4:0]              flags_q, flags_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DatWidth-1:0]     dat_q, dat_d;
  logic                    to_q, to_d;
  logic                    ovf_q, ovf_d;
  logic                    irq_q, irq_d;
  logic [2:0]              rst_cnt_q, rst_cnt_d;

  logic                    req, stall, timer_hit, do_access, do_timeout;
  logic [2:0]              adr;
  logic                    cmd_push, cmd_pop, rsp_push, rsp_pop;
  logic                    flush_cmd, flush_rsp;
  logic [7:0]              cmd_data, rsp_data;
  logic [LvlWidth-1:0]     cmd_level, rsp_level;
  logic                    cmd_empty, cmd_full, cmd_empty_nx;
  logic                    rsp_empty, rsp_full, rsp_empty_nx;
  logic [DatWidth-1:0]     status_word;
  logic                    unused_ok;

  // Only the low three address bits and a few data bits are decoded.
  assign unused_ok = ^{wb_sel_i, wb_adr_i, wb_dat_i};

  ucaspian_wb_fifo #(.Depth(FifoDepth)) u_cmd_fifo (
    .clk_i        (wb_clk_i),
    .rst_ni       (wb_rst_ni),
    .flush_i      (flush_cmd),
    .push_i       (cmd_push),
    .data_i       (wb_dat_i[7:0]),
    .pop_i        (cmd_pop),
    .data_o       (cmd_data),
    .level_o      (cmd_level),
    .empty_o      (cmd_empty),
    .full_o       (cmd_full),
    .empty_next_o (cmd_empty_nx)
  );

  ucaspian_wb_fifo #(.Depth(FifoDepth)) u_rsp_fifo (
    .clk_i        (wb_clk_i),
    .rst_ni       (wb_rst_ni),
    .flush_i      (flush_rsp),
    .push_i       (rsp_push),
    .data_i       (s_data_i),
    .pop_i        (rsp_pop),
    .data_o       (rsp_data),
    .level_o      (rsp_level),
    .empty_o      (rsp_empty),
    .full_o       (rsp_full),
    .empty_next_o (rsp_empty_nx)
  );

  assign m_data_o  = cmd_data;
  assign m_valid_o = ~cmd_empty;
  assign cmd_pop   = m_valid_o & m_ready_i;
  assign s_ready_o = ~rsp_full;
  assign rsp_push  = s_valid_i & s_ready_o;

  assign req = wb_stb_i & wb_cyc_i;
  assign adr = wb_adr_i[2:0];

  // Only blocking mode can stall. RSP waits for data; CMD waits for space.
  assign stall = ~flags_q[0] &
                 ((~wb_we_i & (adr == AdrRsp) & rsp_empty) |
                  ( wb_we_i & (adr == AdrCmd) & cmd_full));

  assign timer_hit = (limit_q != '0) && (timer_q == limit_q);

  always_comb begin
    status_word        = '0;
    status_word[0]     = cmd_full;
    status_word[1]     = rsp_empty;
    status_word[2]     = to_q;
    status_word[3]     = ovf_q;
    status_word[7:4]   = Version;
    status_word[15:8]  = 8'(cmd_level);
    status_word[23:16] = 8'(rsp_level);
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    limit_d    = limit_q;
    flags_d    = flags_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = '0;
    to_d       = to_q;
    ovf_d      = ovf_q;
    cmd_push   = 1'b0;
    rsp_pop    = 1'b0;
    flush_cmd  = 1'b0;
    flush_rsp  = 1'b0;
    do_access  = 1'b0;
    do_timeout = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (stall) begin
            // The timer starts at 1 here, so it reaches the limit L
            // in the L-th WAIT cycle.
            state_d = StWait;
            timer_d = TimeoutWidth'(1);
          end else begin
            do_access = 1'b1;
          end
        end
      end
      StWait: begin
        if (!req) begin
          // The master has abandoned the cycle, so leave with no side effect.
          state_d = StIdle;
        end else if (!stall) begin
          do_access = 1'b1;
        end else if (timer_hit) begin
          do_timeout = 1'b1;
        end else begin
          timer_d = timer_q + TimeoutWidth'(1);
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (do_access) begin
      state_d = StAck;
      ack_d   = 1'b1;
      if (wb_we_i) begin
        unique case (adr)
          AdrCmd: begin
            // Reaching here with the FIFO full only happens in non-blocking mode.
            if (cmd_full) begin
              ovf_d = 1'b1;
            end else begin
              cmd_push = 1'b1;
            end
          end
          AdrCtrl: begin
            flags_d = wb_dat_i[4:0];
            limit_d = wb_dat_i[8 +: TimeoutWidth];
          end
          AdrClear: begin
            flush_cmd = wb_dat_i[0];
            flush_rsp = wb_dat_i[1];
            if (wb_dat_i[2]) to_d  = 1'b0;
            if (wb_dat_i[3]) ovf_d = 1'b0;
          end
          default: ;
        endcase
      end else begin
        unique case (adr)
          AdrStatus: dat_d = status_word;
          AdrRsp: begin
            if (!rsp_empty) begin
              dat_d   = DatWidth'({1'b1, rsp_data});
              rsp_pop = 1'b1;
            end
          end
          AdrCtrl: dat_d = DatWidth'({limit_q, 3'b000, flags_q});
          default: ;
        endcase
      end
    end

    if (do_timeout) begin
      state_d = StAck;
      to_d    = 1'b1;
      if (ErrEnable) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
      end
    end
  end

  // The interrupt is built from next-state values, so it moves on the same
  // edge as the FIFO or register change that causes it.
  assign irq_d = (flags_d[1] & ~rsp_empty_nx) |
                 (flags_d[2] &  cmd_empty_nx) |
                 (flags_d[3] &  to_d);

  // Down-counter that holds the core in reset for a few cycles after release.
  assign rst_cnt_d = (rst_cnt_q != 3'd0) ? rst_cnt_q - 3'd1 : rst_cnt_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      limit_q   <= TimeoutWidth'(DefaultTimeout);
      flags_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      to_q      <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      rst_cnt_q <= 3'd4;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      limit_q   <= limit_d;
      flags_q   <= flags_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      to_q      <= to_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_err_o     = err_q;
  assign wb_dat_o     = dat_q;
  assign irq_o        = irq_q;
  assign core_reset_o = (rst_cnt_q != 3'd0) | flags_q[4];

endmodule

// File: tb/tb_ucaspian_wb_bridge.sv
module tb_ucaspian_wb_bridge;

  logic        clk;
  logic        rst_n;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc;
  logic        wb_ack, wb_err;
  logic        irq;
  logic [7:0]  m_data;
  logic        m_valid, m_ready;
  logic [7:0]  s_data;
  logic        s_valid, s_ready;
  logic        core_rst;

  int n_test = 0;
  int n_fail = 0;

  ucaspian_wb_bridge dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_dat_w),
    .wb_dat_o     (wb_dat_r),
    .wb_sel_i     (wb_sel),
    .wb_we_i      (wb_we),
    .wb_stb_i     (wb_stb),
    .wb_cyc_i     (wb_cyc),
    .wb_ack_o     (wb_ack),
    .wb_err_o     (wb_err),
    .irq_o        (irq),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .core_reset_o (core_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_test++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [2:0] adr, input logic [31:0] wdat,
                      output logic [31:0] rdat, output logic acked, output logic erred,
                      output int ncyc);
    wb_adr   = '0;
    wb_adr[2:0] = adr;
    wb_we    = we;
    wb_dat_w = wdat;
    wb_stb   = 1'b1;
    wb_cyc   = 1'b1;
    rdat  = '0;
    acked = 1'b0;
    erred = 1'b0;
    ncyc  = 0;
    while (ncyc < 300) begin
      tick();
      ncyc++;
      if (wb_ack || wb_err) begin
        acked = wb_ack;
        erred = wb_err;
        rdat  = wb_dat_r;
        break;
      end
    end
    check("bus_terminated", {31'b0, acked | erred}, 32'd1);
    wb_stb = 1'b0;
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    logic a, e;
    int n;
    xfer(1'b0, adr, 32'h0, d, a, e, n);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input string tag);
    logic [31:0] d;
    logic a, e;
    int n;
    xfer(1'b1, adr, dat, d, a, e, n);
    check(tag, {31'b0, a}, 32'd1);
  endtask

  logic [31:0] d;
  logic        a, e;
  int          n;

  initial begin
    rst_n = 1'b0;
    wb_adr = '0; wb_dat_w = '0; wb_sel = 4'hF;
    wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    m_ready = 1'b0; s_data = 8'h00; s_valid = 1'b0;

    // Reset values
    tick();
    check("rst_core_reset", {31'b0, core_rst}, 32'd1);
    check("rst_s_ready", {31'b0, s_ready}, 32'd1);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_ack_err_irq", {29'b0, wb_ack, wb_err, irq}, 32'd0);
    check("rst_dat", wb_dat_r, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("core_reset_3_after", {31'b0, core_rst}, 32'd1);
    tick();
    check("core_reset_4_after", {31'b0, core_rst}, 32'd0);

    rd(3'd0, 32'h0000_0022, "status_reset");
    rd(3'd3, 32'h0000_7F00, "ctrl_reset");

    // Three command bytes held back by the core
    wr(3'd2, 32'h11, "cmd_wr_11");
    wr(3'd2, 32'h22, "cmd_wr_22");
    wr(3'd2, 32'h33, "cmd_wr_33");
    rd(3'd0, 32'h0000_0322, "status_cmd3");
    m_ready = 1'b1;
    check("m_data_0", {23'b0, m_valid, m_data}, 32'h111);
    tick();
    check("m_data_1", {23'b0, m_valid, m_data}, 32'h122);
    tick();
    check("m_data_2", {23'b0, m_valid, m_data}, 32'h133);
    tick();
    check("m_drained", {31'b0, m_valid}, 32'd0);
    m_ready = 1'b0;

    // One response byte from the core
    s_data = 8'hA5; s_valid = 1'b1;
    check("s_ready_empty", {31'b0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
    rd(3'd0, 32'h0001_0020, "status_rsp1");
    rd(3'd1, 32'h0000_01A5, "rsp_read_a5");
    rd(3'd0, 32'h0000_0022, "status_after_pop");

    // Blocking read on empty with limit 5 times out
    wr(3'd3, 32'h0000_0500, "ctrl_limit5");
    rd(3'd3, 32'h0000_0500, "ctrl_readback");
    xfer(1'b0, 3'd1, 32'h0, d, a, e, n);
    check("timeout_err", {30'b0, a, e}, 32'd1);
    check("timeout_cycles", n, 32'd6);
    check("timeout_data", d, 32'd0);
    rd(3'd0, 32'h0000_0026, "status_timeout_sticky");

    // Non-blocking: fill the command FIFO, then overflow it
    wr(3'd3, 32'h0000_0501, "ctrl_nonblock");
    for (int i = 0; i < 32; i++) begin
      xfer(1'b1, 3'd2, 32'(8'h40 + 8'(i)), d, a, e, n);
    end
    rd(3'd0, 32'h0000_2027, "status_cmd_full");
    xfer(1'b1, 3'd2, 32'hEE, d, a, e, n);
    check("overflow_ack", {30'b0, a, e}, 32'd2);
    check("overflow_cycles", n, 32'd1);
    rd(3'd0, 32'h0000_202F, "status_overflow");
    check("cmd_head_kept", {23'b0, m_valid, m_data}, 32'h140);
    xfer(1'b0, 3'd1, 32'h0, d, a, e, n);
    check("nb_rsp_empty_ack", {30'b0, a, e}, 32'd2);
    check("nb_rsp_empty_data", d, 32'h000);
    check("nb_rsp_empty_cycles", n, 32'd1);

    // Clear everything
    wr(3'd4, 32'hF, "clear_all");
    rd(3'd0, 32'h0000_0022, "status_cleared");
    check("m_valid_flushed", {31'b0, m_valid}, 32'd0);

    // irq on rsp non-empty
    wr(3'd3, 32'h0000_0502, "ctrl_irq_rsp");
    check("irq_idle", {31'b0, irq}, 32'd0);
    s_data = 8'h5C; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check("irq_rise", {31'b0, irq}, 32'd1);
    wr(3'd4, 32'h2, "clear_rsp");
    check("irq_fall", {31'b0, irq}, 32'd0);
    rd(3'd0, 32'h0000_0022, "status_rsp_flushed");

    // Blocking read abandoned by the master in WAIT
    wb_adr = '0; wb_adr[2:0] = 3'd1; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    tick(); tick(); tick();
    check("abort_wait_no_term", {30'b0, wb_ack, wb_err}, 32'd0);
    wb_stb = 1'b0; wb_cyc = 1'b0;
    tick();
    check("abort_no_term_1", {30'b0, wb_ack, wb_err}, 32'd0);
    tick();
    check("abort_no_term_2", {30'b0, wb_ack, wb_err}, 32'd0);
    s_data = 8'h77; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    rd(3'd0, 32'h0001_0020, "status_byte_kept");
    check("irq_byte_kept", {31'b0, irq}, 32'd1);
    rd(3'd1, 32'h0000_0177, "rsp_read_77");

    // Core soft reset
    wr(3'd3, 32'h0000_0512, "ctrl_soft_reset");
    check("soft_reset_on", {31'b0, core_rst}, 32'd1);
    wr(3'd3, 32'h0000_0502, "ctrl_soft_reset_off");
    check("soft_reset_off", {31'b0, core_rst}, 32'd0);

    // Writes to RO and unused addresses, reads of WO registers
    wr(3'd0, 32'hFFFF_FFFF, "status_wr_ignored");
    rd(3'd0, 32'h0000_0022, "status_unchanged");
    rd(3'd2, 32'h0, "cmd_read_zero");
    rd(3'd4, 32'h0, "clear_read_zero");
    rd(3'd5, 32'h0, "unmapped_read_zero");
    wr(3'd7, 32'h1234_5678, "unmapped_wr_ack");
    rd(3'd3, 32'h0000_0502, "ctrl_unchanged");

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
